// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
// Contents: forwarding select encodings, controller FSM state type and a
// register-match helper used by both the forwarding and the hazard logic.
package pipe_ctrl_pkg;

  localparam logic [1:0] FWD_REG   = 2'b00;  // register file qa/qb
  localparam logic [1:0] FWD_EXR   = 2'b01;  // EX ALU result r
  localparam logic [1:0] FWD_MEMR  = 2'b10;  // MEM ALU result mr
  localparam logic [1:0] FWD_MEMDO = 2'b11;  // MEM load data mdo

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } ctrl_state_t;

  // A stage supplies a source operand when it writes a register, that
  // register is not $0, and it is the register being read.
  function automatic logic reg_match(input logic       wr,
                                     input logic [4:0] dest,
                                     input logic [4:0] src);
    return wr && (dest != 5'd0) && (dest == src);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source register.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the select follows the current EX/MEM fields.
// Ports: src (source reg number), EX fields (edest_reg, ewreg, em2reg),
// MEM fields (mdest_reg, mwreg, mm2reg), sel (2-bit forwarding select).
module fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] edest_reg,
  input  logic       ewreg,
  input  logic       em2reg,
  input  logic [4:0] mdest_reg,
  input  logic       mwreg,
  input  logic       mm2reg,
  output logic [1:0] sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit  = reg_match(ewreg, edest_reg, src);
  assign mem_hit = reg_match(mwreg, mdest_reg, src);

  // A load in EX has no data yet, so it never produces FWD_EXR; that case
  // is stalled by the load-use logic and picked up from MEM next cycle.
  always_comb begin
    sel = FWD_REG;
    if (ex_hit && !em2reg) begin
      sel = FWD_EXR;
    end else if (mem_hit) begin
      sel = mm2reg ? FWD_MEMDO : FWD_MEMR;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: forwarding selects, load-use bubble and
// a wait-state FSM freezing all stages during a data-memory handshake.
// Latency: selects/enables combinational; mem_err and counters one cycle.
// Backpressure: freeze while MEM access lacks dmem_ack, bounded by MAX_WAIT.
// Ports: clock/reset; rs, rt, uses_rs, uses_rt (ID); edestReg, ewreg,
// em2reg (EX); mdestReg, mwreg, mm2reg, mwmem (MEM); dmem_ack in;
// fwda, fwdb, pc_we, ifid_we, idex_we, exmem_we, memwb_we, idex_bubble,
// dmem_req, mem_err out. Define PIPE_CTRL_PERF_EN to add load_use_cnt and
// mem_wait_cnt saturating performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             uses_rs,
  input  logic             uses_rt,
  input  logic [4:0]       edestReg,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       mdestReg,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic             mwmem,
  input  logic             dmem_ack,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             idex_we,
  output logic             exmem_we,
  output logic             memwb_we,
  output logic             idex_bubble,
  output logic             dmem_req,
  output logic             mem_err
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] load_use_cnt,
  output logic [CNT_W-1:0] mem_wait_cnt
`endif
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255 || CNT_W < 1) begin : g_bad_param
    $error("pipeline_ctrl: MAX_WAIT must be 1..255 and CNT_W >= 1");
  end

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_nxt;
  logic        freeze;
  logic        timeout;
  logic        mem_op;
  logic        load_use;
  logic [1:0]  sel_a;
  logic [1:0]  sel_b;

  fwd_sel u_fwd_a (
    .src       (rs),
    .edest_reg (edestReg),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .mdest_reg (mdestReg),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .sel       (sel_a)
  );

  fwd_sel u_fwd_b (
    .src       (rt),
    .edest_reg (edestReg),
    .ewreg     (ewreg),
    .em2reg    (em2reg),
    .mdest_reg (mdestReg),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .sel       (sel_b)
  );

  assign mem_op = mm2reg | mwmem;

  // Unlike the selects, the hazard only counts operands actually read.
  assign load_use = ewreg && em2reg &&
                    ((uses_rs && reg_match(ewreg, edestReg, rs)) ||
                     (uses_rt && reg_match(ewreg, edestReg, rt)));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (timeout) begin
        mem_err <= 1'b1;
      end
    end
  end

  // wait_cnt counts freeze cycles of the current access; the cycle where it
  // equals MAX_WAIT is the release cycle, giving exactly MAX_WAIT freezes.
  always_comb begin
    state_nxt   = state;
    wait_nxt    = wait_cnt;
    freeze      = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      RUN: begin
        if (mem_op && !dmem_ack) begin
          freeze    = 1'b1;
          state_nxt = WAIT;
          wait_nxt  = 8'd1;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == MAX_WAIT_C) begin
          timeout   = 1'b1;
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else begin
          freeze    = 1'b1;
          wait_nxt  = wait_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 8'd0;
      end
    endcase
  end

  // Freeze overrides the load-use stall; reset forces everything idle.
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    idex_we     = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    idex_bubble = 1'b0;
    dmem_req    = 1'b0;
    fwda        = FWD_REG;
    fwdb        = FWD_REG;
    if (!reset) begin
      fwda     = sel_a;
      fwdb     = sel_b;
      dmem_req = mem_op;
      if (!freeze) begin
        idex_we     = 1'b1;
        exmem_we    = 1'b1;
        memwb_we    = 1'b1;
        pc_we       = !load_use;
        ifid_we     = !load_use;
        idex_bubble = load_use;
      end
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      load_use_cnt <= '0;
      mem_wait_cnt <= '0;
    end else begin
      if (idex_bubble && (load_use_cnt != {CNT_W{1'b1}})) begin
        load_use_cnt <= load_use_cnt + 1'b1;
      end
      if (freeze && (mem_wait_cnt != {CNT_W{1'b1}})) begin
        mem_wait_cnt <= mem_wait_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl built with MAX_WAIT = 4.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipeline_ctrl;

  logic       clock;
  logic       reset;
  logic [4:0] rs, rt, edestReg, mdestReg;
  logic       uses_rs, uses_rt, ewreg, em2reg, mwreg, mm2reg, mwmem, dmem_ack;
  logic [1:0] fwda, fwdb;
  logic       pc_we, ifid_we, idex_we, exmem_we, memwb_we;
  logic       idex_bubble, dmem_req, mem_err;
  logic [4:0] we;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] load_use_cnt, mem_wait_cnt;
`endif

  int pass_n = 0;
  int chk_n  = 0;

  assign we = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};

  pipeline_ctrl #(.MAX_WAIT(4), .CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .rs          (rs),
    .rt          (rt),
    .uses_rs     (uses_rs),
    .uses_rt     (uses_rt),
    .edestReg    (edestReg),
    .ewreg       (ewreg),
    .em2reg      (em2reg),
    .mdestReg    (mdestReg),
    .mwreg       (mwreg),
    .mm2reg      (mm2reg),
    .mwmem       (mwmem),
    .dmem_ack    (dmem_ack),
    .fwda        (fwda),
    .fwdb        (fwdb),
    .pc_we       (pc_we),
    .ifid_we     (ifid_we),
    .idex_we     (idex_we),
    .exmem_we    (exmem_we),
    .memwb_we    (memwb_we),
    .idex_bubble (idex_bubble),
    .dmem_req    (dmem_req),
    .mem_err     (mem_err)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .load_use_cnt(load_use_cnt),
    .mem_wait_cnt(mem_wait_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear_inputs();
    rs = 5'd0; rt = 5'd0; uses_rs = 1'b0; uses_rt = 1'b0;
    edestReg = 5'd0; ewreg = 1'b0; em2reg = 1'b0;
    mdestReg = 5'd0; mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    rs = 5'd3; rt = 5'd3; ewreg = 1'b1; edestReg = 5'd3; mwmem = 1'b1;
    @(negedge clock); #1;
    chk_n++; if (we !== 5'b00000) $display("FAIL rst_we got=%b exp=00000", we); else pass_n++;
    chk_n++; if (idex_bubble !== 1'b0) $display("FAIL rst_bubble got=%b exp=0", idex_bubble); else pass_n++;
    chk_n++; if (dmem_req !== 1'b0) $display("FAIL rst_req got=%b exp=0", dmem_req); else pass_n++;
    chk_n++; if ({fwda, fwdb} !== 4'b0000) $display("FAIL rst_fwd got=%b_%b exp=00_00", fwda, fwdb); else pass_n++;
    chk_n++; if (mem_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", mem_err); else pass_n++;
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk_n++; if (we !== 5'b11111) $display("FAIL rst_release_we got=%b exp=11111", we); else pass_n++;
  endtask

  // Store in MEM acked on the 4th cycle: three frozen cycles then release.
  task automatic test_mem_wait();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      clear_inputs();
      if (i < 4) mwmem = 1'b1;
      dmem_ack = (i == 3);
      #1;
      chk_n++;
      if (we !== ((i < 3) ? 5'b00000 : 5'b11111))
        $display("FAIL store_wait_c%0d we got=%b exp=%b", i, we, (i < 3) ? 5'b00000 : 5'b11111);
      else pass_n++;
    end
    chk_n++; if (dmem_req !== 1'b0) $display("FAIL store_req_after got=%b exp=0", dmem_req); else pass_n++;
    // An ack with no access outstanding must not disturb the pipeline.
    @(negedge clock);
    dmem_ack = 1'b1;
    #1;
    chk_n++; if (we !== 5'b11111) $display("FAIL stray_ack we got=%b exp=11111", we); else pass_n++;
    @(negedge clock);
    clear_inputs();
    #1;
    chk_n++; if (we !== 5'b11111) $display("FAIL stray_ack_after we got=%b exp=11111", we); else pass_n++;
`ifdef PIPE_CTRL_PERF_EN
    chk_n++; if (mem_wait_cnt !== 32'd3) $display("FAIL perf_mem_wait got=%0d exp=3", mem_wait_cnt); else pass_n++;
    chk_n++; if (load_use_cnt !== 32'd0) $display("FAIL perf_load_use got=%0d exp=0", load_use_cnt); else pass_n++;
`endif
  endtask

  task automatic test_forwarding();
    @(negedge clock);
    clear_inputs();
    rs = 5'd3; ewreg = 1'b1; edestReg = 5'd3;
    #1;
    chk_n++; if (fwda !== 2'b01) $display("FAIL fwd_ex_alu got=%b exp=01", fwda); else pass_n++;
    // MEM load match; ack now so no freeze is started.
    ewreg = 1'b0; mwreg = 1'b1; mdestReg = 5'd3; mm2reg = 1'b1; dmem_ack = 1'b1;
    #1;
    chk_n++; if (fwda !== 2'b11) $display("FAIL fwd_mem_load got=%b exp=11", fwda); else pass_n++;
    clear_inputs();
    ewreg = 1'b1; edestReg = 5'd0; rs = 5'd0;
    #1;
    chk_n++; if (fwda !== 2'b00) $display("FAIL fwd_reg0 got=%b exp=00", fwda); else pass_n++;
    // EX has priority over MEM; rt path.
    clear_inputs();
    rt = 5'd7; ewreg = 1'b1; edestReg = 5'd7; mwreg = 1'b1; mdestReg = 5'd7;
    #1;
    chk_n++; if (fwdb !== 2'b01) $display("FAIL fwd_ex_prio got=%b exp=01", fwdb); else pass_n++;
    // Load in EX does not supply data: falls to MEM ALU match.
    em2reg = 1'b1;
    #1;
    chk_n++; if (fwdb !== 2'b10) $display("FAIL fwd_exload_mem got=%b exp=10", fwdb); else pass_n++;
    clear_inputs();
    rt = 5'd9; mwreg = 1'b1; mdestReg = 5'd9;
    #1;
    chk_n++; if (fwdb !== 2'b10) $display("FAIL fwd_mem_alu got=%b exp=10", fwdb); else pass_n++;
    chk_n++; if (fwda !== 2'b00) $display("FAIL fwd_nomatch got=%b exp=00", fwda); else pass_n++;
  endtask

  task automatic test_load_use();
    @(negedge clock);
    clear_inputs();
    ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd5; rt = 5'd5; uses_rt = 1'b1;
    #1;
    chk_n++; if (we !== 5'b00111) $display("FAIL lu_stall we got=%b exp=00111", we); else pass_n++;
    chk_n++; if (idex_bubble !== 1'b1) $display("FAIL lu_bubble got=%b exp=1", idex_bubble); else pass_n++;
    @(negedge clock);
    clear_inputs();
    rt = 5'd5; uses_rt = 1'b1; mwreg = 1'b1; mm2reg = 1'b1; mdestReg = 5'd5; dmem_ack = 1'b1;
    #1;
    chk_n++; if (fwdb !== 2'b11) $display("FAIL lu_next_fwdb got=%b exp=11", fwdb); else pass_n++;
    chk_n++; if ({we, idex_bubble} !== 6'b111110) $display("FAIL lu_next_we got=%b_%b exp=11111_0", we, idex_bubble); else pass_n++;
    // Matching but unused operand: no stall.
    @(negedge clock);
    clear_inputs();
    ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd5; rt = 5'd5;
    #1;
    chk_n++; if ({we, idex_bubble} !== 6'b111110) $display("FAIL lu_unused got=%b_%b exp=11111_0", we, idex_bubble); else pass_n++;
    // rs side of the hazard.
    rs = 5'd5; uses_rs = 1'b1;
    #1;
    chk_n++; if ({we, idex_bubble} !== 6'b001111) $display("FAIL lu_rs got=%b_%b exp=00111_1", we, idex_bubble); else pass_n++;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic test_hazard_during_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      clear_inputs();
      ewreg = 1'b1; em2reg = 1'b1; edestReg = 5'd6; rs = 5'd6; uses_rs = 1'b1;
      mwmem = 1'b1; dmem_ack = (i == 2);
      #1;
      chk_n++;
      if ({we, idex_bubble} !== ((i < 2) ? 6'b000000 : 6'b001111))
        $display("FAIL hz_wait_c%0d got=%b_%b exp=%b", i, we, idex_bubble, (i < 2) ? 6'b000000 : 6'b001111);
      else pass_n++;
    end
    @(negedge clock);
    clear_inputs();
    rs = 5'd6; uses_rs = 1'b1; mwreg = 1'b1; mm2reg = 1'b1; mdestReg = 5'd6; dmem_ack = 1'b1;
    #1;
    chk_n++; if ({we, idex_bubble} !== 6'b111110) $display("FAIL hz_after got=%b_%b exp=11111_0", we, idex_bubble); else pass_n++;
    chk_n++; if (fwda !== 2'b11) $display("FAIL hz_after_fwda got=%b exp=11", fwda); else pass_n++;
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      clear_inputs();
      mm2reg = 1'b1; mwreg = 1'b1; mdestReg = 5'd8;
      #1;
      chk_n++;
      if (we !== ((i < 4) ? 5'b00000 : 5'b11111))
        $display("FAIL tmo_c%0d we got=%b exp=%b", i, we, (i < 4) ? 5'b00000 : 5'b11111);
      else pass_n++;
    end
    chk_n++; if (mem_err !== 1'b0) $display("FAIL tmo_err_early got=%b exp=0", mem_err); else pass_n++;
    @(negedge clock);
    clear_inputs();
    #1;
    chk_n++; if (mem_err !== 1'b1) $display("FAIL tmo_err got=%b exp=1", mem_err); else pass_n++;
    chk_n++; if (we !== 5'b11111) $display("FAIL tmo_resume we got=%b exp=11111", we); else pass_n++;
  endtask

  // Access held straight after an acked release starts fresh from RUN.
  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      clear_inputs();
      mwmem = 1'b1; dmem_ack = (i == 1);
      #1;
      chk_n++;
      if (we !== ((i == 1) ? 5'b11111 : 5'b00000))
        $display("FAIL b2b_c%0d we got=%b exp=%b", i, we, (i == 1) ? 5'b11111 : 5'b00000);
      else pass_n++;
    end
    @(negedge clock);
    clear_inputs();
    mwmem = 1'b1; dmem_ack = 1'b1;
    #1;
    chk_n++; if (we !== 5'b11111) $display("FAIL b2b_release we got=%b exp=11111", we); else pass_n++;
    chk_n++; if (mem_err !== 1'b1) $display("FAIL b2b_err_sticky got=%b exp=1", mem_err); else pass_n++;
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      clear_inputs();
      mm2reg = 1'b1;
    end
    reset = 1'b1;
    #1;
    chk_n++; if (we !== 5'b00000) $display("FAIL rmw_we got=%b exp=00000", we); else pass_n++;
    chk_n++; if (dmem_req !== 1'b0) $display("FAIL rmw_req got=%b exp=0", dmem_req); else pass_n++;
    chk_n++; if (mem_err !== 1'b0) $display("FAIL rmw_err got=%b exp=0", mem_err); else pass_n++;
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    #1;
    chk_n++; if (we !== 5'b11111) $display("FAIL rmw_run we got=%b exp=11111", we); else pass_n++;
`ifdef PIPE_CTRL_PERF_EN
    chk_n++; if ({load_use_cnt, mem_wait_cnt} !== 64'd0) $display("FAIL rmw_perf got=%0d/%0d exp=0/0", load_use_cnt, mem_wait_cnt); else pass_n++;
`endif
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_mem_wait();
    test_forwarding();
    test_load_use();
    test_hazard_during_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_n, chk_n);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencing controller for the 5-stage pipelined datapath. Computes the `fwda`/`fwdb` forwarding selects and detects load-use hazards. Drives per-stage register write enables and the ID/EX bubble. Runs a wait-state FSM that freezes the whole pipeline while a MEM-stage load or store waits on a variable-latency data-memory handshake, with a timeout error.

## Interface
- `MAX_WAIT`, 16: maximum freeze cycles per memory access before timeout, legal range 1..255.
- `CNT_W`, 32: width of the performance counters.

- `clock`  in  1: pipeline clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `rs`, `rt`  in  5 each: ID-stage source register numbers.
- `uses_rs`, `uses_rt`  in  1 each: ID instruction actually reads rs / rt.
- `edestReg`  in  5: EX-stage destination register.
- `ewreg`, `em2reg`  in  1 each: EX-stage write-reg and load flags.
- `mdestReg`  in  5: MEM-stage destination register.
- `mwreg`, `mm2reg`, `mwmem`  in  1 each: MEM-stage write-reg, load and store flags.
- `dmem_ack`  in  1: data memory completion pulse, one cycle per access.
- `fwda`, `fwdb`  out  2: forwarding selects.
  - 00: register file (`qa`/`qb`).
  - 01: EX ALU result `r`.
  - 10: MEM ALU result `mr`.
  - 11: MEM load data `mdo`.
- `pc_we`, `ifid_we`, `idex_we`, `exmem_we`, `memwb_we`  out  1 each: stage register enables.
- `idex_bubble`  out  1: load zeros (NOP controls) into ID/EX this edge.
- `dmem_req`  out  1: memory access request.
- `mem_err`  out  1: sticky timeout flag.
- `load_use_cnt`, `mem_wait_cnt`  out  `CNT_W` each: present only with `PIPE_CTRL_PERF_EN`.

## Operation
- Operand match rule, applied to rs for `fwda` and to rt for `fwdb`:
  - A source matches a stage when that stage's write flag = 1, its destReg ≠ 0, and its destReg equals the source.
  - An EX match with `em2reg` = 0 gives 01.
  - Otherwise, a MEM match gives 11 if `mm2reg` = 1, else 10.
  - Otherwise 00.
  - EX takes priority over MEM.
  - The selects are purely combinational from the current inputs. They are not gated by `uses_*`.
- Load-use hazard: EX matches with `em2reg` = 1, on (rs with `uses_rs`) or (rt with `uses_rt`). Response:
  - `pc_we` = 0, `ifid_we` = 0, `idex_bubble` = 1.
  - All other enables = 1.
  - Lasts exactly one cycle. The next cycle the load is in MEM and the select resolves to 11.
- `mem_op` = `mm2reg` | `mwmem`. `dmem_req` = `mem_op` while not in reset.
- FSM states: RUN, WAIT.
  - RUN:
    - If `mem_op` and !`dmem_ack`: freeze, go to WAIT, set `wait_cnt` = 1.
    - Otherwise no freeze.
  - WAIT:
    - Freeze is held.
    - If `dmem_ack`: release freeze this cycle and go to RUN.
    - Else if `wait_cnt` = `MAX_WAIT`: set `mem_err`, release freeze this cycle and go to RUN. The access is treated as complete.
    - Else increment `wait_cnt`.
- Freeze:
  - All five `_we` = 0 and `idex_bubble` = 0.
  - Freeze overrides load-use.
  - A hazard present during freeze is re-evaluated after release.
- Register-file write-before-read handles WB-to-ID forwarding; it is not in scope here.

## Timing
- Reset values:
  - State RUN, `wait_cnt` = 0, `mem_err` = 0, counters 0.
  - While `reset` = 1: all `_we` = 0, `idex_bubble` = 0, `dmem_req` = 0, `fwda`/`fwdb` = 00.
- Reset mid-WAIT returns to RUN immediately, asynchronously.
- An ack in the same cycle as the request gives zero freeze cycles.
- An ack that arrives when the FSM is in RUN with no `mem_op` is ignored.
- The timeout releases after exactly `MAX_WAIT` freeze cycles.
- The first cycle of a new access directly after a release is evaluated from RUN.
- `mem_err` clears only on reset.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `load_use_cnt` increments on each bubble cycle.
  - `mem_wait_cnt` increments on each freeze cycle.
  - Both saturate at all-ones.
- Undefined: the counters and their ports are absent. All other behaviour is identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - `FWD_REG` = 2'b00, `FWD_EXR` = 2'b01, `FWD_MEMR` = 2'b10, `FWD_MEMDO` = 2'b11.
  - `ctrl_state_t` {RUN, WAIT}.
- Sub-module `fwd_sel`: one source register number plus the EX/MEM fields in, 2-bit select out. It is instantiated twice, for rs and rt.

## Test plan
- rs = 3 with EX `ewreg` = 1, `edestReg` = 3, `em2reg` = 0 → `fwda` = 01. Same rs with MEM `mdestReg` = 3, `mm2reg` = 1 and no EX match → `fwda` = 11. With `edestReg` = 0 → 00.
- Load to $5 in EX, ID instruction with rt = 5 and `uses_rt` = 1 → one cycle of `pc_we` = `ifid_we` = 0, `idex_bubble` = 1. Next cycle `fwdb` = 11 and all enables = 1.
- Store in MEM with `dmem_ack` after 3 cycles → 3 cycles with all `_we` = 0, release on the ack cycle. With `PIPE_CTRL_PERF_EN`, `mem_wait_cnt` = 3.
- `MAX_WAIT` = 4, never ack → exactly 4 freeze cycles, `mem_err` = 1 and stays 1, pipeline resumes.
- Load-use hazard coincident with a MEM wait → no bubble while frozen. After the ack, exactly one bubble cycle.
- Reset asserted in the 2nd WAIT cycle → enables 0 during reset. After deassert the FSM is in RUN, `mem_err` = 0, counters 0.
